// File: rtl/bdd_node_walker.sv
// -----------------------------------------------------------------------------
// bdd_node_walker
//
// Read-side initiator for the node SRAM holding a binary decision diagram.
// On an accepted start it latches a root node address and a variable
// assignment vector, then fetches one node per two cycles. It follows the
// high or low pointer selected by the assigned value of the node's variable.
// The walk stops at a terminal node, or when the decision-step limit is
// reached, in which case it reports an error.
//
// Node word layout (LSB first):
//   low pointer  [ADDR_WIDTH-1:0]
//   high pointer [2*ADDR_WIDTH-1:ADDR_WIDTH]
//   var index    next VAR_WIDTH bits
//   value        next bit (terminal result)
//   terminal     next bit
//   anything above the terminal flag is ignored
//
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_start            start request, only looked at while idle
//   i_root             root node address, latched with i_start
//   i_assign           variable assignment (bit v = value of variable v)
//   o_busy             high from the cycle after accept through the done cycle
//   o_done             one-cycle completion pulse
//   o_result           terminal value, held until the next accepted start
//   o_error            step limit hit, held like o_result
//   o_steps            decision nodes traversed, held like o_result
//   o_mem_addr         registered SRAM address
//   o_mem_write        SRAM write enable (always 0, read-only initiator)
//   o_mem_data         SRAM write data (always 0)
//   i_mem_data         SRAM read data, valid the cycle after the address edge
//
// DATA_WIDTH must be at least 2*ADDR_WIDTH+VAR_WIDTH+2.
// -----------------------------------------------------------------------------
module bdd_node_walker #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int VAR_WIDTH  = 4,
  parameter int MAX_STEPS  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_root,
  input  logic [2**VAR_WIDTH-1:0] i_assign,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_result,
  output logic                    o_error,
  output logic [ADDR_WIDTH:0]     o_steps,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic                    o_mem_write,
  output logic [DATA_WIDTH-1:0]   o_mem_data,
  input  logic [DATA_WIDTH-1:0]   i_mem_data
);

  // Bit positions of the node word fields.
  localparam int HIGH_LSB = ADDR_WIDTH;
  localparam int VAR_LSB  = 2 * ADDR_WIDTH;
  localparam int VAL_BIT  = VAR_LSB + VAR_WIDTH;
  localparam int TERM_BIT = VAL_BIT + 1;

  localparam int STEP_W = ADDR_WIDTH + 1;
  // The step counter reaches LAST_STEP on the final permitted decision node;
  // a non-terminal node seen there ends the walk with the counter at the limit.
  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(MAX_STEPS - 1);
  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state_reg,  state_next;
  logic [2**VAR_WIDTH-1:0]   assign_reg, assign_next;
  logic [ADDR_WIDTH-1:0]     addr_reg,   addr_next;
  logic [STEP_W-1:0]         steps_reg,  steps_next;
  logic                      result_reg, result_next;
  logic                      error_reg,  error_next;

  // Decoded fields of the node word currently on the read bus.
  logic [ADDR_WIDTH-1:0] node_low;
  logic [ADDR_WIDTH-1:0] node_high;
  logic [VAR_WIDTH-1:0]  node_var;
  logic                  node_value;
  logic                  node_term;

  assign node_low   = i_mem_data[ADDR_WIDTH-1:0];
  assign node_high  = i_mem_data[HIGH_LSB +: ADDR_WIDTH];
  assign node_var   = i_mem_data[VAR_LSB +: VAR_WIDTH];
  assign node_value = i_mem_data[VAL_BIT];
  assign node_term  = i_mem_data[TERM_BIT];

  // Upper node-word bits carry no meaning here; fold them away so they are
  // visibly consumed. Only exists when the word is wider than the fields.
  generate
    if (DATA_WIDTH > TERM_BIT + 1) begin : g_spare_bits
      logic unused_spare_bits;
      assign unused_spare_bits = ^i_mem_data[DATA_WIDTH-1:TERM_BIT+1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg  <= IDLE;
      assign_reg <= '0;
      addr_reg   <= '0;
      steps_reg  <= '0;
      result_reg <= 1'b0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      assign_reg <= assign_next;
      addr_reg   <= addr_next;
      steps_reg  <= steps_next;
      result_reg <= result_next;
      error_reg  <= error_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    assign_next = assign_reg;
    addr_next   = addr_reg;
    steps_next  = steps_reg;
    result_next = result_reg;
    error_next  = error_reg;

    case (state_reg)
      IDLE: begin
        if (i_start) begin
          assign_next = i_assign;
          addr_next   = i_root;
          steps_next  = '0;
          result_next = 1'b0;
          error_next  = 1'b0;
          state_next  = FETCH;
        end
      end

      // The address register is stable here; the SRAM samples it on the
      // edge that leaves this state, so data is on the bus during WAIT.
      FETCH: begin
        state_next = WAIT;
      end

      WAIT: begin
        if (node_term) begin
          result_next = node_value;
          state_next  = DONE;
        end else if (steps_reg == LAST_STEP) begin
          steps_next  = STEP_LIMIT;
          error_next  = 1'b1;
          result_next = 1'b0;
          state_next  = DONE;
        end else begin
          steps_next = steps_reg + STEP_ONE;
          addr_next  = assign_reg[node_var] ? node_high : node_low;
          state_next = FETCH;
        end
      end

      // Start requests seen here are dropped; the block only listens in IDLE.
      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_busy      = (state_reg != IDLE);
  assign o_done      = (state_reg == DONE);
  assign o_result    = result_reg;
  assign o_error     = error_reg;
  assign o_steps     = steps_reg;
  assign o_mem_addr  = addr_reg;
  assign o_mem_write = 1'b0;
  assign o_mem_data  = '0;

endmodule

// File: tb/tb_bdd_node_walker.sv
// -----------------------------------------------------------------------------
// tb_bdd_node_walker
//
// Self-checking bench for bdd_node_walker. Provides a registered-read SRAM
// model, a table of directed walks over the reference node image, hand-written
// multi-cycle sequences (ignored start, continuous start, reset mid-walk) and
// randomized walks over random node images checked against a direct
// walk-the-graph reference model.
// -----------------------------------------------------------------------------
module tb_bdd_node_walker;

  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int VW  = 4;
  localparam int MAX = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [AW-1:0]   root;
  logic [2**VW-1:0] asg;
  logic            busy, done, result, error;
  logic [AW:0]     steps;
  logic [AW-1:0]   mem_addr;
  logic            mem_write;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  logic [DW-1:0]   mem [16];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Single-port SRAM read: address sampled at the edge, data valid next cycle.
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  bdd_node_walker #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .VAR_WIDTH(VW), .MAX_STEPS(MAX)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_root(root),
    .i_assign(asg), .o_busy(busy), .o_done(done), .o_result(result),
    .o_error(error), .o_steps(steps), .o_mem_addr(mem_addr),
    .o_mem_write(mem_write), .o_mem_data(mem_wdata), .i_mem_data(mem_rdata)
  );

  typedef struct {
    logic [AW-1:0]    root;
    logic [2**VW-1:0] asg;
    bit               res;
    bit               err;
    int               steps;
    int               cycles;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the stored graph directly. Each visited node is one
  // fetch (two cycles); the done pulse follows one cycle after the last.
  function automatic void model(input logic [AW-1:0] r, input logic [2**VW-1:0] a,
                                output bit res, output bit err,
                                output int nsteps, output int cycles);
    logic [AW-1:0] p;
    logic [DW-1:0] w;
    p = r;
    res = 1'b0;
    err = 1'b0;
    for (int k = 0; k < MAX; k++) begin
      w = mem[p];
      if (w[13]) begin
        res    = w[12];
        nsteps = k;
        cycles = 2 * (k + 1) + 1;
        return;
      end
      p = a[w[11:8]] ? w[7:4] : w[3:0];
    end
    err    = 1'b1;
    res    = 1'b0;
    nsteps = MAX;
    cycles = 2 * MAX + 1;
  endfunction

  task automatic load_reference_image();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 32'h0000_3000;
    mem[1] = 32'h0000_2000;
    mem[2] = 32'h0000_0001;
    mem[3] = 32'h0000_0221;
    mem[4] = 32'h0000_0044;
  endtask

  // Request a walk, count cycles from the accepting edge to o_done, and
  // compare the reported results and timing against the expectation.
  task automatic do_walk(input logic [AW-1:0] r, input logic [2**VW-1:0] a,
                         input bit exp_res, input bit exp_err,
                         input int exp_steps, input int exp_cycles,
                         input string tag);
    int  cyc;
    bit  seen;
    bit  busy_ok;
    @(negedge clk);
    start = 1'b1;
    root  = r;
    asg   = a;
    @(negedge clk);   // accepting edge has passed; this is cycle 1
    start   = 1'b0;
    root    = ~r;     // latched value must be used, not the live input
    asg     = ~a;
    cyc     = 1;
    seen    = 1'b0;
    busy_ok = 1'b1;
    while (cyc <= 100) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_busy"}, busy_ok && busy, 1);
    check({tag, "_cycles"}, cyc, exp_cycles);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_steps"}, steps, exp_steps);
    check({tag, "_no_write"}, {mem_write, mem_wdata}, 0);
    $display("walk %s root=%0d assign=%h done@%0d result=%0d error=%0d steps=%0d",
             tag, r, a, cyc, result, error, steps);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_held"}, {error, result, steps}, {exp_err, exp_res, 5'(exp_steps)});
  endtask

  vec_t vecs[4];

  initial begin
    bit rr, re;
    int rs, rc;
    int done_count;

    reset = 1'b1;
    start = 1'b0;
    root  = '0;
    asg   = '0;
    load_reference_image();

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_outputs", {busy, done, result, error, steps, mem_addr}, 0);
    $display("reset released, outputs idle");

    // ---------------- table-driven directed walks ----------------
    vecs[0] = '{root: 4'd0, asg: 16'h0000, res: 1'b1, err: 1'b0, steps: 0,  cycles: 3};
    vecs[1] = '{root: 4'd3, asg: 16'h0005, res: 1'b1, err: 1'b0, steps: 2,  cycles: 7};
    vecs[2] = '{root: 4'd3, asg: 16'h0001, res: 1'b0, err: 1'b0, steps: 1,  cycles: 5};
    vecs[3] = '{root: 4'd4, asg: 16'hFFFF, res: 1'b0, err: 1'b1, steps: 16, cycles: 33};
    for (int i = 0; i < 4; i++) begin
      do_walk(vecs[i].root, vecs[i].asg, vecs[i].res, vecs[i].err,
              vecs[i].steps, vecs[i].cycles, $sformatf("vec%0d", i));
    end

    // ---------------- start pulse mid-walk is ignored ----------------
    @(negedge clk);
    start = 1'b1; root = 4'd0; asg = '0;
    @(negedge clk);                        // cycle 1
    start = 1'b0;
    check("ign_c1_busy", busy, 1);
    @(negedge clk);                        // cycle 2
    check("ign_c2_busy", busy, 1);
    start = 1'b1; root = 4'd3; asg = 16'h0001;
    @(negedge clk);                        // cycle 3
    start = 1'b0;
    check("ign_done_c3", {busy, done, result, error, steps}, {1'b1, 1'b1, 1'b1, 1'b0, 5'd0});
    done_count = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || done) done_count++;
    end
    check("ign_no_second_walk", done_count, 0);
    $display("walk ignored-start root=0 result=%0d steps=%0d", result, steps);

    // ---------------- continuous start re-triggers ----------------
    @(negedge clk);
    start = 1'b1; root = 4'd0; asg = '0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("cont_done_c%0d", c), done, (c == 3 || c == 7) ? 1 : 0);
      check($sformatf("cont_busy_c%0d", c), busy, (c == 4) ? 0 : 1);
    end
    start = 1'b0;
    @(negedge clk);
    check("cont_idle", busy, 0);
    $display("walk continuous-start two walks done at cycles 3 and 7");

    // ---------------- reset mid-walk ----------------
    @(negedge clk);
    start = 1'b1; root = 4'd3; asg = 16'h0005;
    @(negedge clk);                        // cycle 1
    start = 1'b0;
    done_count = 0;
    repeat (3) begin                       // cycles 2..4
      @(negedge clk);
      if (done) done_count++;
    end
    check("rst_addr_moved", mem_addr, 2);
    reset = 1'b1;
    @(negedge clk);                        // cycle 5
    reset = 1'b0;
    check("rst_outputs", {busy, done, result, error, steps, mem_addr}, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) done_count++;
    end
    check("rst_no_done", done_count, 0);
    $display("reset mid-walk aborted cleanly");
    do_walk(4'd1, 16'h0000, 1'b0, 1'b0, 0, 3, "post_reset");

    // ---------------- randomized walks against the model ----------------
    for (int img = 0; img < 3; img++) begin
      for (int i = 0; i < 16; i++) begin
        mem[i]     = $urandom;
        mem[i][13] = ($urandom_range(0, 2) == 0);
      end
      if (img == 2) mem[$urandom_range(0, 15)] = 32'h0000_0000;
      for (int t = 0; t < 15; t++) begin
        logic [AW-1:0]    r;
        logic [2**VW-1:0] a;
        r = 4'($urandom_range(0, 15));
        a = 16'($urandom);
        model(r, a, rr, re, rs, rc);
        do_walk(r, a, rr, re, rs, rc, $sformatf("rnd%0d_%0d", img, t));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
